sound_player: RTL and testbench
===============================

Name: sound_player

Overview:
- Downstream consumer of the logo block's `mute` and `code_sound` outputs.
- Turns each sound event into a square-wave tone sequence on a single speaker/buzzer pin.
- Runs on the VGA pixel clock domain alongside the logo and sync blocks.
- Tone frequencies and durations are derived from the clock-rate parameter, so benches can use a small clock rate.

Parameters:
- CLK_HZ, 25000000, system clock frequency in Hz.
- F_HI, 1000, high tone frequency in Hz.
- F_LO, 500, low tone frequency in Hz.
- TONE_DIV, 10, tone duration = CLK_HZ/TONE_DIV cycles (100 ms by default).
- Derived constants, integer division:
  - HP_HI = CLK_HZ/(2*F_HI)
  - HP_LO = CLK_HZ/(2*F_LO)
  - TONE_CYC = CLK_HZ/TONE_DIV
- All counters are 24 bits wide; every derived constant must be ≥2 and <2^24.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- mute  input  1  1 = silence/abort; a 1→0 transition starts a sound.
- code_sound  input  2  00 ping, 01 pong, 10 go, 11 stop.
- speaker  output  1  square-wave drive to the buzzer.
- busy  output  1  1 while a sound is playing.

Behaviour:
- Reset (clr=1, asynchronous) sets:
  - state=IDLE, speaker=0, busy=0, mute_q=0, code_l=00, hp_cnt=0, dur_cnt=0.
- mute_q is a registered copy of mute. trig = mute_q & ~mute (falling edge of mute).
  - mute_q resets to 0, so mute held low out of reset never triggers.
- States:
  - IDLE (busy=0, speaker=0)
  - TONE1 (busy=1)
  - TONE2 (busy=1)
- IDLE transition: if trig in cycle N, latch code_l=code_sound, clear both counters and enter TONE1 at N+1. Speaker stays 0 at N+1.
- Tone selection:
  - TONE1 half-period: ping=HP_HI, pong=HP_LO, go=HP_LO, stop=HP_HI.
  - TONE2 half-period: go=HP_HI, stop=HP_LO.
  - ping and pong have no TONE2.
- Tone generation, each cycle in TONE1/TONE2:
  - hp_cnt increments.
  - When hp_cnt==HP-1, speaker toggles and hp_cnt returns to 0.
  - First speaker rise is at cycle N+1+HP.
- Duration, each cycle in TONE1/TONE2:
  - dur_cnt increments.
  - When dur_cnt==TONE_CYC-1, the tone ends (each tone lasts exactly TONE_CYC cycles).
- End of TONE1:
  - ping/pong → IDLE, speaker=0.
  - go/stop → TONE2, counters cleared, speaker forced 0.
- End of TONE2 → IDLE, speaker=0.
- Total busy time: TONE_CYC cycles (ping/pong) or 2*TONE_CYC cycles (go/stop).
- Abort: mute sampled 1 while in TONE1/TONE2 → IDLE on the next edge, speaker=0, busy=0. Abort has priority over tone end.
- code_sound changes while busy are ignored (code_l holds).
- Retrigger: a trig can only follow mute=1, which has already aborted, so each new sound always starts cleanly from IDLE.
- Async clr mid-tone: speaker and busy drop to 0 immediately, without waiting for a clock edge.
- Both outputs are registered; no combinational path from inputs to outputs.

Test Plan:
All scenarios use CLK_HZ=20000, so HP_HI=10, HP_LO=20, TONE_CYC=2000.
1. Reset, then hold mute=0 for 5000 cycles → speaker=0 and busy=0 throughout (no spurious trigger).
2. Ping (code 00; mute 1 then 0 at cycle N):
   - busy=1 from N+1 through N+2000, then 0.
   - speaker toggles every 10 cycles, first rise at N+11: exactly 100 rising edges, speaker=0 after.
3. Go (code 10):
   - busy=1 for 4000 cycles.
   - First 2000 cycles: period 40, 50 rises.
   - Next 2000 cycles: period 20, 100 rises.
   - Speaker=0 at the tone boundary cycle.
4. Stop (code 11): first tone period 20 (100 rises), second tone period 40 (50 rises). During playback, change code_sound to 00 at cycle 300 → waveform unchanged.
5. Pong abort: set mute=1 at cycle 500 of the tone → next edge busy=0 and speaker=0. Then mute 1→0 with code 00 → a fresh ping of 2000 cycles.
6. Ping in progress: assert clr asynchronously mid-cycle at cycle 700 → speaker and busy go 0 before the next clk edge. Release clr with mute=0 → no sound.

Source files
------------

// File: rtl/sound_player.sv
// Square-wave tone sequencer for the buzzer pin.
// Plays ping/pong/go/stop sounds started by a falling edge of mute.
module sound_player #(
  parameter int CLK_HZ   = 25000000,
  parameter int F_HI     = 1000,
  parameter int F_LO     = 500,
  parameter int TONE_DIV = 10
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       mute,
  input  logic [1:0] code_sound,
  output logic       speaker,
  output logic       busy
);

  localparam logic [23:0] HP_HI    = 24'(CLK_HZ / (2 * F_HI));
  localparam logic [23:0] HP_LO    = 24'(CLK_HZ / (2 * F_LO));
  localparam logic [23:0] TONE_CYC = 24'(CLK_HZ / TONE_DIV);

  typedef enum logic [1:0] {
    IDLE,
    TONE1,
    TONE2
  } state_t;

  state_t      state, state_n;
  logic        speaker_n;
  logic        busy_n;
  logic        mute_q;
  logic [1:0]  code_l, code_n;
  logic [23:0] hp_cnt, hp_n;
  logic [23:0] dur_cnt, dur_n;
  logic [23:0] hp;
  logic        trig;
  logic        hp_last;
  logic        dur_last;

  assign trig = mute_q & ~mute;

  // ping/stop open high, pong/go open low; go ends high, stop ends low
  always_comb begin
    hp = HP_HI;
    if (state == TONE2) begin
      hp = code_l[0] ? HP_LO : HP_HI;
    end else if (code_l[1] ^ code_l[0]) begin
      hp = HP_LO;
    end
  end

  assign hp_last  = (hp_cnt == hp - 24'd1);
  assign dur_last = (dur_cnt == TONE_CYC - 24'd1);

  always_comb begin
    state_n   = state;
    speaker_n = speaker;
    busy_n    = busy;
    code_n    = code_l;
    hp_n      = hp_cnt;
    dur_n     = dur_cnt;
    unique case (state)
      IDLE: begin
        speaker_n = 1'b0;
        busy_n    = 1'b0;
        if (trig) begin
          state_n = TONE1;
          busy_n  = 1'b1;
          code_n  = code_sound;
          hp_n    = '0;
          dur_n   = '0;
        end
      end
      TONE1, TONE2: begin
        hp_n  = hp_cnt + 24'd1;
        dur_n = dur_cnt + 24'd1;
        if (hp_last) begin
          hp_n      = '0;
          speaker_n = ~speaker;
        end
        // abort wins over the natural end of a tone
        if (mute) begin
          state_n   = IDLE;
          speaker_n = 1'b0;
          busy_n    = 1'b0;
        end else if (dur_last) begin
          speaker_n = 1'b0;
          hp_n      = '0;
          dur_n     = '0;
          if (state == TONE1 && code_l[1]) begin
            state_n = TONE2;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n   = IDLE;
        speaker_n = 1'b0;
        busy_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      speaker <= 1'b0;
      busy    <= 1'b0;
      mute_q  <= 1'b0;
      code_l  <= 2'b00;
      hp_cnt  <= '0;
      dur_cnt <= '0;
    end else begin
      state   <= state_n;
      speaker <= speaker_n;
      busy    <= busy_n;
      mute_q  <= mute;
      code_l  <= code_n;
      hp_cnt  <= hp_n;
      dur_cnt <= dur_n;
    end
  end

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player at CLK_HZ=20000.
// HP_HI=10, HP_LO=20, TONE_CYC=2000.
module tb_sound_player;

  logic       clk = 1'b0;
  logic       clr;
  logic       mute;
  logic [1:0] code_sound;
  logic       speaker;
  logic       busy;

  int tests = 0;
  int fails = 0;

  sound_player #(
    .CLK_HZ  (20000),
    .F_HI    (1000),
    .F_LO    (500),
    .TONE_DIV(10)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .mute      (mute),
    .code_sound(code_sound),
    .speaker   (speaker),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    int         busy_len;
    int         rises1;
    int         rises2;
    int         first_rise;
    bit         chg_code;
  } vec_t;

  vec_t vecs[4];

  int n_busy, n_r1, n_r2, first, last_busy;
  logic spk_bnd;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cycle N: mute falls; returns right after the edge into cycle N
  task automatic trigger(input logic [1:0] c);
    mute = 1'b1;
    tick();
    mute = 1'b0;
    code_sound = c;
  endtask

  // samples cycles N+1 .. N+len
  task automatic measure(input int len, input bit chg);
    logic prev;
    prev = speaker;
    n_busy = 0; n_r1 = 0; n_r2 = 0; first = 0;
    last_busy = 0; spk_bnd = 1'b1;
    for (int j = 1; j <= len; j++) begin
      tick();
      if (busy) begin
        n_busy++;
        last_busy = j;
      end
      if (speaker && !prev) begin
        if (j <= 2000) n_r1++;
        else n_r2++;
        if (first == 0) first = j;
      end
      if (j == 2001) spk_bnd = speaker;
      if (chg && j == 300) code_sound = 2'b00;
      prev = speaker;
    end
  endtask

  initial begin
    int bad;
    vecs[0] = '{2'b00, 2000, 100,   0, 11, 1'b0};
    vecs[1] = '{2'b01, 2000,  50,   0, 21, 1'b0};
    vecs[2] = '{2'b10, 4000,  50, 100, 21, 1'b0};
    vecs[3] = '{2'b11, 4000, 100,  50, 11, 1'b1};

    clr = 1'b1;
    mute = 1'b0;
    code_sound = 2'b00;
    #23;
    check("reset_speaker", int'(speaker), 0);
    check("reset_busy", int'(busy), 0);
    clr = 1'b0;

    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (speaker || busy) bad++;
    end
    check("idle_no_trigger", bad, 0);

    foreach (vecs[k]) begin
      trigger(vecs[k].code);
      measure(4100, vecs[k].chg_code);
      check($sformatf("v%0d_busy_cycles", k), n_busy, vecs[k].busy_len);
      check($sformatf("v%0d_busy_last", k), last_busy, vecs[k].busy_len);
      check($sformatf("v%0d_rises1", k), n_r1, vecs[k].rises1);
      check($sformatf("v%0d_rises2", k), n_r2, vecs[k].rises2);
      check($sformatf("v%0d_first_rise", k), first, vecs[k].first_rise);
      check($sformatf("v%0d_spk_boundary", k), int'(spk_bnd), 0);
      check($sformatf("v%0d_spk_end", k), int'(speaker), 0);
    end

    // pong aborted at cycle 500, then a fresh ping
    trigger(2'b01);
    for (int j = 1; j <= 500; j++) tick();
    check("abort_busy_before", int'(busy), 1);
    mute = 1'b1;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_speaker", int'(speaker), 0);
    mute = 1'b0;
    code_sound = 2'b00;
    measure(2100, 1'b0);
    check("reping_busy", n_busy, 2000);
    check("reping_rises", n_r1, 100);
    check("reping_first", first, 11);

    // asynchronous clear in the middle of a ping
    trigger(2'b00);
    for (int j = 1; j <= 700; j++) tick();
    check("clr_spk_before", int'(speaker), 1);
    check("clr_busy_before", int'(busy), 1);
    #3 clr = 1'b1;
    #1;
    check("clr_speaker_async", int'(speaker), 0);
    check("clr_busy_async", int'(busy), 0);
    tick();
    clr = 1'b0;
    bad = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (speaker || busy) bad++;
    end
    check("clr_no_sound", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
